// File: rtl/axi_line_engine.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_line_engine                                              |
// | Description : Moves one cache line over AXI4 as an 8-beat INCR burst:      |
// |               refill (AR/R into o_rblock) or writeback (AW/W/B from a      |
// |               latched copy of i_wblock).                                   |
// | Option      : AXI_RESP_CHECK_EN - flag bad RRESP/BRESP or misplaced RLAST  |
// |               on o_err; undefined, o_err is tied low.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axi_line_engine #(
  parameter int ADDR_WIDTH     = 64,
  parameter int BLOCK_WIDTH    = 512,
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                          i_clk,
  input  logic                          i_arst,
  input  logic                          i_start,
  input  logic                          i_write,
  input  logic [ADDR_WIDTH-1:0]         i_addr,
  input  logic [BLOCK_WIDTH-1:0]        i_wblock,
  output logic [BLOCK_WIDTH-1:0]        o_rblock,
  output logic                          o_done,
  output logic                          o_busy,
  output logic                          o_err,
  output logic                          o_arvalid,
  input  logic                          i_arready,
  output logic [ADDR_WIDTH-1:0]         o_araddr,
  output logic [7:0]                    o_arlen,
  output logic [2:0]                    o_arsize,
  output logic [1:0]                    o_arburst,
  input  logic                          i_rvalid,
  output logic                          o_rready,
  input  logic [AXI_DATA_WIDTH-1:0]     i_rdata,
  input  logic                          i_rlast,
  input  logic [1:0]                    i_rresp,
  output logic                          o_awvalid,
  input  logic                          i_awready,
  output logic [ADDR_WIDTH-1:0]         o_awaddr,
  output logic [7:0]                    o_awlen,
  output logic [2:0]                    o_awsize,
  output logic [1:0]                    o_awburst,
  output logic                          o_wvalid,
  input  logic                          i_wready,
  output logic [AXI_DATA_WIDTH-1:0]     o_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   o_wstrb,
  output logic                          o_wlast,
  input  logic                          i_bvalid,
  output logic                          o_bready,
  input  logic [1:0]                    i_bresp
);

  localparam int         BEATS     = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int         OFFSET    = $clog2(BLOCK_WIDTH / 8);
  localparam int         SEL_W     = $clog2(BLOCK_WIDTH);
  localparam int         LANE_W    = $clog2(AXI_DATA_WIDTH);
  localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WDATA = 3'd4,
    WRESP = 3'd5
  } state_t;

  state_t                   state, state_next;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [BLOCK_WIDTH-1:0]   wblock_q;
  logic [BLOCK_WIDTH-1:0]   rblock_q;
  logic [2:0]               beat;
  logic                     done_q;
  logic [SEL_W-1:0]         beat_lsb;
  logic                     accept, ar_hs, aw_hs, r_hs, w_hs, b_hs, last_beat, final_hs;
  logic                     unused_addr_lsbs;

  // The low address bits are forced to zero, so they are deliberately dropped.
  assign unused_addr_lsbs = ^i_addr[OFFSET-1:0];

  assign accept    = (state == IDLE) && i_start;
  assign ar_hs     = o_arvalid && i_arready;
  assign aw_hs     = o_awvalid && i_awready;
  assign r_hs      = o_rready && i_rvalid;
  assign w_hs      = o_wvalid && i_wready;
  assign b_hs      = o_bready && i_bvalid;
  assign last_beat = (beat == LAST_BEAT);
  // The burst ends on the counted 8th beat; RLAST is never used to terminate.
  assign final_hs  = (r_hs && last_beat) || b_hs;
  assign beat_lsb  = SEL_W'({beat, {LANE_W{1'b0}}});

  assign o_busy    = (state != IDLE);
  assign o_done    = done_q;
  assign o_rblock  = rblock_q;
  assign o_araddr  = addr_q;
  assign o_awaddr  = addr_q;
  assign o_arlen   = 8'(BEATS - 1);
  assign o_awlen   = 8'(BEATS - 1);
  assign o_arsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign o_awsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign o_arburst = 2'b01;
  assign o_awburst = 2'b01;
  assign o_wstrb   = '1;
  assign o_wdata   = wblock_q[beat_lsb +: AXI_DATA_WIDTH];

  // State register; reset forces IDLE at once, even in the middle of a burst.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state and channel handshake outputs, all decoded from the state.
  always_comb begin
    state_next = state;
    o_arvalid  = 1'b0;
    o_rready   = 1'b0;
    o_awvalid  = 1'b0;
    o_wvalid   = 1'b0;
    o_wlast    = 1'b0;
    o_bready   = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_next = i_write ? WADDR : RADDR;
      end
      RADDR: begin
        o_arvalid = 1'b1;
        if (i_arready) state_next = RDATA;
      end
      RDATA: begin
        o_rready = 1'b1;
        if (i_rvalid && last_beat) state_next = IDLE;
      end
      WADDR: begin
        o_awvalid = 1'b1;
        if (i_awready) state_next = WDATA;
      end
      WDATA: begin
        o_wvalid = 1'b1;
        o_wlast  = last_beat;
        if (i_wready && last_beat) state_next = WRESP;
      end
      WRESP: begin
        o_bready = 1'b1;
        if (i_bvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, beat counting, refill assembly and the done pulse.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      addr_q   <= '0;
      wblock_q <= '0;
      rblock_q <= '0;
      beat     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= final_hs;
      if (accept) begin
        addr_q <= {i_addr[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
        beat   <= '0;
        if (i_write) wblock_q <= i_wblock;
      end
      if (ar_hs || aw_hs) beat <= '0;
      if (r_hs) rblock_q[beat_lsb +: AXI_DATA_WIDTH] <= i_rdata;
      // Counter parks on the last beat so it cannot wrap inside a burst.
      if ((r_hs || w_hs) && !last_beat) beat <= beat + 3'd1;
    end
  end

`ifdef AXI_RESP_CHECK_EN
  logic err_acc, beat_err, err_q;

  // Error seen on the current beat or response handshake.
  always_comb begin
    beat_err = 1'b0;
    if (r_hs) beat_err = (i_rresp != 2'b00) || (i_rlast != last_beat);
    if (b_hs) beat_err = (i_bresp != 2'b00);
  end

  // Sticky per-transfer error, reported alongside the done pulse.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      err_acc <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= final_hs && (err_acc || beat_err);
      if (accept)        err_acc <= 1'b0;
      else if (beat_err) err_acc <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  logic unused_resp;
  assign unused_resp = ^{i_rlast, i_rresp, i_bresp};
  assign o_err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_line_engine.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for axi_line_engine with a refill-block / write-beat scoreboard.
module tb_axi_line_engine;
  localparam int AW = 64;
  localparam int BW = 512;
  localparam int DW = 64;

`ifdef AXI_RESP_CHECK_EN
  localparam logic BRESP_ERR_EXP = 1'b1;
`else
  localparam logic BRESP_ERR_EXP = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_arst, i_start, i_write;
  logic [AW-1:0] i_addr;
  logic [BW-1:0] i_wblock, o_rblock;
  logic o_done, o_busy, o_err;
  logic o_arvalid, i_arready, i_rvalid, o_rready, i_rlast;
  logic [AW-1:0] o_araddr, o_awaddr;
  logic [7:0] o_arlen, o_awlen;
  logic [2:0] o_arsize, o_awsize;
  logic [1:0] o_arburst, o_awburst, i_rresp, i_bresp;
  logic [DW-1:0] i_rdata, o_wdata;
  logic o_awvalid, i_awready, o_wvalid, i_wready, o_wlast, i_bvalid, o_bready;
  logic [DW/8-1:0] o_wstrb;

  always #5 i_clk = ~i_clk;

  axi_line_engine #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .AXI_DATA_WIDTH(DW)) dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_start(i_start), .i_write(i_write),
    .i_addr(i_addr), .i_wblock(i_wblock), .o_rblock(o_rblock), .o_done(o_done),
    .o_busy(o_busy), .o_err(o_err),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
    .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata),
    .i_rlast(i_rlast), .i_rresp(i_rresp),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
    .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata),
    .o_wstrb(o_wstrb), .o_wlast(o_wlast),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp)
  );

  int n_asrt = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [BW-1:0] rq[$];
  logic [DW-1:0] wq[$];
  logic [BW-1:0] last_rblock;

  task automatic tick();
    @(negedge i_clk);
    cyc++;
  endtask

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_done(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      if (o_done) begin
        at = cyc;
        break;
      end
      tick();
    end
    check("done_seen", BW'(at != -1), BW'(1));
  endtask

  task automatic after_done();
    tick();
    check("done_one_cycle", BW'(o_done), BW'(0));
    check("idle_after_done", BW'(o_busy), BW'(0));
  endtask

  // abort_beat >= 0 pulls reset while that beat would be presented.
  task automatic refill(input logic [AW-1:0] addr, input logic [DW-1:0] seed,
                        input int ar_stall, input int abort_beat);
    logic [BW-1:0] blk_exp;
    logic [AW-1:0] line;
    int c0, at;
    line      = addr & ~AW'(BW/8 - 1);
    blk_exp   = '0;
    i_start   = 1'b1;
    i_write   = 1'b0;
    i_addr    = addr;
    i_arready = (ar_stall == 0);
    c0        = cyc;
    tick();
    i_start = 1'b0;
    check("ar_len", BW'(o_arlen), BW'(7));
    check("ar_size", BW'(o_arsize), BW'(3));
    check("ar_burst", BW'(o_arburst), BW'(1));
    for (int i = 0; i < ar_stall; i++) begin
      check("ar_valid_hold", BW'(o_arvalid), BW'(1));
      check("ar_addr_hold", BW'(o_araddr), BW'(line));
      i_start = (i == 1);
      i_write = (i == 1);
      tick();
    end
    i_start = 1'b0;
    i_write = 1'b0;
    check("ar_valid", BW'(o_arvalid), BW'(1));
    check("ar_addr", BW'(o_araddr), BW'(line));
    i_arready = 1'b1;
    tick();
    i_arready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == abort_beat) begin
        i_arst = 1'b0;
        #1;
        check("rst_busy", BW'(o_busy), BW'(0));
        check("rst_rready", BW'(o_rready), BW'(0));
        check("rst_arvalid", BW'(o_arvalid), BW'(0));
        check("rst_done", BW'(o_done), BW'(0));
        check("rst_rblock", o_rblock, BW'(0));
        tick();
        i_arst   = 1'b1;
        i_rvalid = 1'b0;
        i_rlast  = 1'b0;
        return;
      end
      i_rvalid = 1'b1;
      i_rdata  = seed + DW'(k);
      i_rlast  = (k == 7);
      blk_exp[k*DW +: DW] = seed + DW'(k);
      check("r_ready", BW'(o_rready), BW'(1));
      tick();
    end
    i_rvalid = 1'b0;
    i_rlast  = 1'b0;
    rq.push_back(blk_exp);
    wait_done(20, at);
    check("refill_latency", BW'(at - c0), BW'(10 + ar_stall));
    if (rq.size() > 0) begin
      last_rblock = rq.pop_front();
      check("rblock", o_rblock, last_rblock);
    end
    check("refill_err", BW'(o_err), BW'(0));
    after_done();
  endtask

  task automatic writeback(input logic [AW-1:0] addr, input logic [DW-1:0] seed,
                           input bit toggle, input logic [1:0] bresp, input logic err_exp);
    logic [AW-1:0] line;
    int c0, at, b_cyc, guard;
    line = addr & ~AW'(BW/8 - 1);
    for (int k = 0; k < 8; k++) begin
      i_wblock[k*DW +: DW] = seed + DW'(k);
      wq.push_back(seed + DW'(k));
    end
    i_start   = 1'b1;
    i_write   = 1'b1;
    i_addr    = addr;
    i_awready = 1'b1;
    c0        = cyc;
    tick();
    i_start  = 1'b0;
    i_write  = 1'b0;
    i_wblock = '0;
    check("aw_valid", BW'(o_awvalid), BW'(1));
    check("aw_addr", BW'(o_awaddr), BW'(line));
    check("aw_len", BW'(o_awlen), BW'(7));
    check("aw_size", BW'(o_awsize), BW'(3));
    check("aw_burst", BW'(o_awburst), BW'(1));
    tick();
    i_awready = 1'b0;
    guard = 0;
    while (wq.size() > 0 && guard < 40) begin
      i_wready = toggle ? (guard % 2 == 0) : 1'b1;
      check("w_valid", BW'(o_wvalid), BW'(1));
      check("w_data", BW'(o_wdata), BW'(wq[0]));
      check("w_last", BW'(o_wlast), BW'(wq.size() == 1));
      check("w_strb", BW'(o_wstrb), BW'(8'hFF));
      if (i_wready) void'(wq.pop_front());
      tick();
      guard++;
    end
    check("w_all_beats", BW'(wq.size()), BW'(0));
    wq.delete();
    i_wready = 1'b0;
    i_bvalid = 1'b1;
    i_bresp  = bresp;
    check("b_ready", BW'(o_bready), BW'(1));
    check("w_idle_in_resp", BW'(o_wvalid), BW'(0));
    b_cyc = cyc;
    tick();
    i_bvalid = 1'b0;
    i_bresp  = 2'b00;
    wait_done(20, at);
    check("done_after_b", BW'(at), BW'(b_cyc + 1));
    if (!toggle) check("wb_latency", BW'(at - c0), BW'(11));
    check("wb_err", BW'(o_err), BW'(err_exp));
    after_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_arst = 1'b0; i_start = 1'b0; i_write = 1'b0; i_addr = '0; i_wblock = '0;
    i_arready = 1'b0; i_rvalid = 1'b0; i_rdata = '0; i_rlast = 1'b0; i_rresp = 2'b00;
    i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b00;
    last_rblock = '0;
    repeat (3) tick();
    check("reset_busy", BW'(o_busy), BW'(0));
    check("reset_done", BW'(o_done), BW'(0));
    check("reset_err", BW'(o_err), BW'(0));
    check("reset_valids", BW'({o_arvalid, o_awvalid, o_wvalid}), BW'(0));
    check("reset_readies", BW'({o_rready, o_bready}), BW'(0));
    check("reset_rblock", o_rblock, BW'(0));
    i_arst = 1'b1;
    tick();

    refill(64'h1047, 64'h0, 0, -1);
    check("rblock_lo", BW'(o_rblock[63:0]), BW'(0));
    check("rblock_hi", BW'(o_rblock[511:448]), BW'(7));

    writeback(64'h2010, 64'hA0, 1'b1, 2'b00, 1'b0);
    check("rblock_hold", o_rblock, last_rblock);

    writeback(64'h3000, 64'hB0, 1'b0, 2'd2, BRESP_ERR_EXP);

    refill(64'h4000_0123, 64'h100, 5, -1);

    refill(64'h5000, 64'h200, 0, 4);
    refill(64'h6040, 64'h300, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_line_engine.md
AXI_LINE_ENGINE -- requirements
Module: axi_line_engine

Interface
REQ-001 SHALL have parameters, one per line:
- ADDR_WIDTH, 64, address width.
- BLOCK_WIDTH, 512, cache line width.
- AXI_DATA_WIDTH, 64, AXI beat width; BEATS = BLOCK_WIDTH/AXI_DATA_WIDTH = 8.

REQ-002 SHALL have ports, one per line:
- i_clk  in  1  sole clock; all state on rising edge.
- i_arst  in  1  asynchronous, active-low reset.
- i_start  in  1  request a line transfer.
- i_write  in  1  operation select, sampled with i_start: 1 = writeback, 0 = refill.
- i_addr  in  ADDR_WIDTH  line address.
- i_wblock  in  BLOCK_WIDTH  line to write back.
- o_rblock  out  BLOCK_WIDTH  assembled refill line.
- o_done  out  1  one-cycle completion pulse.
- o_busy  out  1  transfer in progress.
- o_err  out  1  error flag, valid with o_done.
- o_arvalid  out  1  AR valid.
- i_arready  in  1  AR ready.
- o_araddr  out  ADDR_WIDTH  read burst address.
- o_arlen/o_arsize/o_arburst  out  8/3/2  constants BEATS-1, log2(AXI_DATA_WIDTH/8), INCR.
- i_rvalid  in  1  R valid.
- o_rready  out  1  R ready.
- i_rdata  in  AXI_DATA_WIDTH  read beat.
- i_rlast  in  1  last read beat.
- i_rresp  in  2  read response.
- o_awvalid  out  1  AW valid.
- i_awready  in  1  AW ready.
- o_awaddr  out  ADDR_WIDTH  write burst address.
- o_awlen/o_awsize/o_awburst  out  8/3/2  same constants as AR.
- o_wvalid  out  1  W valid.
- i_wready  in  1  W ready.
- o_wdata  out  AXI_DATA_WIDTH  write beat.
- o_wstrb  out  AXI_DATA_WIDTH/8  constant all ones.
- o_wlast  out  1  last write beat.
- i_bvalid  in  1  B valid.
- o_bready  out  1  B ready.
- i_bresp  in  2  write response.

Function
REQ-003 SHALL implement FSM states IDLE, RADDR, RDATA, WADDR, WDATA, WRESP.
REQ-004 SHALL accept i_start only in IDLE; i_start in any other state SHALL be ignored. o_busy = (state != IDLE).
REQ-005 SHALL latch i_addr with its low log2(BLOCK_WIDTH/8) bits forced to 0 on acceptance. On a writeback, SHALL also latch i_wblock on acceptance.
REQ-006 SHALL follow AXI valid/ready rules: once valid is high, it and the associated address/data SHALL hold until the handshake.
REQ-007 Refill sequence: IDLE -> RADDR (o_arvalid = 1) -> RDATA on i_arready. o_rready SHALL be 1 throughout RDATA. Beat k (k = 0..7) SHALL be written to o_rblock[64k +: 64].
REQ-008 SHALL terminate the read on the 8th beat handshake, regardless of i_rlast, and return to IDLE.
REQ-009 Writeback sequence: IDLE -> WADDR (o_awvalid) -> WDATA on i_awready. Beat k SHALL drive latched block bits [64k +: 64], with o_wlast = 1 on beat 7. After the 8th beat: WRESP with o_bready = 1 until i_bvalid, then IDLE.
REQ-010 SHALL assert o_done for exactly one cycle, in the cycle after the final handshake (last R beat or B handshake).
REQ-011 Zero-wait latency: start in cycle 0; AR or AW handshake in cycle 1; refill data in cycles 2-9 with o_done in cycle 10; writeback data in cycles 2-9, B in cycle 10, o_done in cycle 11.
REQ-012 o_rblock SHALL hold its value from o_done until the next refill's first beat.
REQ-013 The beat counter SHALL be 3 bits, reset to 0 at each burst start, and never wrap mid-burst.

Reset
REQ-014 While i_arst = 0, the FSM SHALL enter IDLE immediately, even mid-burst. All valid/ready/o_done/o_err/o_busy outputs SHALL be 0, and o_rblock and the beat counter SHALL be 0.
REQ-015 SHALL resume accepting i_start on the first clock edge after reset deassertion.

Configuration
REQ-016 Macro AXI_RESP_CHECK_EN defined: o_err SHALL be set with o_done if any i_rresp or i_bresp is non-zero, or if i_rlast differs from (beat == 7) on any beat.
REQ-017 Macro AXI_RESP_CHECK_EN undefined: responses and i_rlast SHALL be ignored, and o_err SHALL be constant 0.

Verification
REQ-018 Refill, zero-wait, i_addr=0x1047, beats 0x0..0x7 -> o_araddr=0x1040, o_arlen=7, o_done in cycle 10, o_rblock[63:0]=0, o_rblock[511:448]=7.
REQ-019 Writeback, i_wblock word k = k+0xA0, i_wready toggling 1/0 -> 8 beats 0xA0..0xA7 in order, o_wlast on 0xA7 only, o_done one cycle after the B handshake.
REQ-020 i_arready held 0 for 5 cycles -> o_arvalid and o_araddr stable for all 5 cycles; second i_start during busy -> ignored.
REQ-021 i_arst low during refill beat 4 -> outputs 0 immediately; new refill after release -> completes normally.
REQ-022 With AXI_RESP_CHECK_EN, i_bresp=2 -> o_err=1 with o_done. Without the macro, same stimulus -> o_err=0.
